// File: rtl/vga_pattern_pkg.sv
// Shared definitions for the VGA test-pattern source: mode encodings,
// the eight-entry RGB444 palette and the fixed pixel colours.
package vga_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_BARS    = 2'd0,
        MODE_CHECKER = 2'd1,
        MODE_GRID    = 2'd2,
        MODE_SOLID   = 2'd3
    } mode_e;

    localparam logic [11:0] PIX_BLACK   = 12'h000;
    localparam logic [11:0] PIX_WHITE   = 12'hFFF;
    localparam logic [11:0] PIX_GRID_BG = 12'h004;

    // Entry 0 is the rightmost element: red, green, blue, yellow,
    // magenta, cyan, white, black.
    localparam logic [7:0][11:0] PALETTE = {
        12'h000, 12'hFFF, 12'h0FF, 12'hF0F,
        12'hFF0, 12'h00F, 12'h0F0, 12'hF00
    };

    function automatic logic [11:0] palette_rgb(input logic [2:0] idx);
        return PALETTE[idx];
    endfunction

endpackage

// File: rtl/vga_frame_tick.sv
// Frame-end detector and completed-frame counter. The tick is asserted
// combinationally while the last visible pixel of a frame is requested;
// the counter advances on the following clock edge and wraps 255 -> 0.
module vga_frame_tick #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 11
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] row_i,
    input  logic [ADDR_W-1:0] col_i,
    input  logic              read_pixel_n_i,
    output logic              frame_tick_o,
    output logic [7:0]        frame_count_o
);

    logic [7:0] frame_count_q;
    logic [7:0] frame_count_d;

    assign frame_tick_o = (read_pixel_n_i == 1'b0)
                       && (row_i == ADDR_W'(V_ACTIVE - 1))
                       && (col_i == ADDR_W'(H_ACTIVE - 1));

    // Next frame count: advance once per completed frame.
    always_comb begin
        frame_count_d = frame_count_q;
        if (frame_tick_o) begin
            frame_count_d = frame_count_q + 8'd1;
        end else begin
            frame_count_d = frame_count_q;
        end
    end

    // Frame counter register.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_count_q <= 8'd0;
        end else begin
            frame_count_q <= frame_count_d;
        end
    end

    assign frame_count_o = frame_count_q;

endmodule

// File: rtl/vga_pattern_gen.sv
// Multi-mode test-pattern source for vga_driver. Answers each pixel request
// with registered RGB444 data one cycle later. Modes: colour bars, checker,
// grid and a solid colour that steps every 32 frames. Mode changes are
// requested with mode_req and take effect only at the frame boundary.
// Optional feature: define VGA_PATTERN_SCROLL_EN to make the bars scroll
// left by SCROLL_STEP pixels per frame while BARS is active.
module vga_pattern_gen
    import vga_pattern_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int ADDR_W      = 11,
    parameter int NUM_BARS    = 7,
    parameter int BAR_W       = 100,
    parameter int CHECK_LOG2  = 5,
    parameter int GRID_LOG2   = 6,
    parameter int SCROLL_STEP = 1
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] row_address,
    input  logic [ADDR_W-1:0] col_address,
    input  logic              read_pixel_n,
    input  logic [1:0]        mode_sel,
    input  logic              mode_req,
    output logic              mode_ack,
    output logic [1:0]        active_mode,
    output logic [7:0]        frame_count,
    output logic [11:0]       pixel_data
);

    localparam int PERIOD = NUM_BARS * BAR_W;
    localparam int PIX_W  = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    // Wide enough to hold off + SCROLL_STEP before the modulo wrap.
    localparam int OFF_W  = $clog2(PERIOD + SCROLL_STEP);
    localparam logic [2:0]       LAST_BAR = 3'(NUM_BARS - 1);
    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(BAR_W - 1);

    logic              frame_tick_s;
    logic [7:0]        frame_count_s;

    logic [11:0]       pixel_q, pixel_d;
    mode_e             active_mode_q, active_mode_d;
    mode_e             pend_mode_q, pend_mode_d;
    logic              pend_flag_q, pend_flag_d;
    logic              mode_ack_q, mode_ack_d;
    logic [2:0]        bar_idx_q, bar_idx_d;
    logic [PIX_W-1:0]  bar_pix_q, bar_pix_d;

    logic [OFF_W-1:0]  off_s;
    logic [2:0]        start_idx_s;
    logic [PIX_W-1:0]  start_pix_s;
    logic              line_start_s;
    logic [2:0]        cur_idx_s;
    logic [PIX_W-1:0]  cur_pix_s;

    vga_frame_tick #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .ADDR_W   (ADDR_W)
    ) u_frame_tick (
        .vga_clk        (vga_clk),
        .reset_n        (reset_n),
        .row_i          (row_address),
        .col_i          (col_address),
        .read_pixel_n_i (read_pixel_n),
        .frame_tick_o   (frame_tick_s),
        .frame_count_o  (frame_count_s)
    );

`ifdef VGA_PATTERN_SCROLL_EN
    logic [OFF_W-1:0] off_q, off_d;
    logic [31:0]      off_sum_s;

    assign off_sum_s = 32'(off_q) + 32'(SCROLL_STEP);

    // Next scroll offset: advance modulo the bar period at each frame end in BARS.
    always_comb begin
        off_d = off_q;
        if (frame_tick_s && (active_mode_q == MODE_BARS)) begin
            if (off_sum_s >= 32'(PERIOD)) begin
                off_d = OFF_W'(off_sum_s - 32'(PERIOD));
            end else begin
                off_d = OFF_W'(off_sum_s);
            end
        end else begin
            off_d = off_q;
        end
    end

    // Scroll offset register; kept across mode changes.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            off_q <= '0;
        end else begin
            off_q <= off_d;
        end
    end

    assign off_s = off_q;
`else
    assign off_s = '0;
`endif

    // Phase of the bar pattern at column 0 for the current offset.
    assign start_idx_s  = 3'(32'(off_s) / 32'(BAR_W));
    assign start_pix_s  = PIX_W'(32'(off_s) % 32'(BAR_W));
    assign line_start_s = (read_pixel_n == 1'b0) && (col_address == '0);

    // Bar position for this request: reload at line start, else follow counters.
    always_comb begin
        cur_idx_s = bar_idx_q;
        cur_pix_s = bar_pix_q;
        if (line_start_s) begin
            cur_idx_s = start_idx_s;
            cur_pix_s = start_pix_s;
        end else begin
            cur_idx_s = bar_idx_q;
            cur_pix_s = bar_pix_q;
        end
    end

    // Bar counters advance by one pixel per visible request.
    always_comb begin
        bar_idx_d = bar_idx_q;
        bar_pix_d = bar_pix_q;
        if (!read_pixel_n) begin
            if (cur_pix_s == LAST_PIX) begin
                bar_pix_d = '0;
                if (cur_idx_s == LAST_BAR) begin
                    bar_idx_d = 3'd0;
                end else begin
                    bar_idx_d = cur_idx_s + 3'd1;
                end
            end else begin
                bar_pix_d = cur_pix_s + PIX_W'(1);
                bar_idx_d = cur_idx_s;
            end
        end else begin
            bar_idx_d = bar_idx_q;
            bar_pix_d = bar_pix_q;
        end
    end

    // Pixel colour for the current request in the active mode.
    always_comb begin
        pixel_d = PIX_BLACK;
        if (read_pixel_n) begin
            pixel_d = PIX_BLACK;
        end else begin
            case (active_mode_q)
                MODE_BARS: begin
                    pixel_d = palette_rgb(cur_idx_s);
                end
                MODE_CHECKER: begin
                    if (col_address[CHECK_LOG2] ^ row_address[CHECK_LOG2]) begin
                        pixel_d = PIX_WHITE;
                    end else begin
                        pixel_d = PIX_BLACK;
                    end
                end
                MODE_GRID: begin
                    if ((col_address[GRID_LOG2-1:0] == {GRID_LOG2{1'b0}})
                        || (row_address[GRID_LOG2-1:0] == {GRID_LOG2{1'b0}})
                        || (col_address == ADDR_W'(H_ACTIVE - 1))
                        || (row_address == ADDR_W'(V_ACTIVE - 1))) begin
                        pixel_d = PIX_WHITE;
                    end else begin
                        pixel_d = PIX_GRID_BG;
                    end
                end
                MODE_SOLID: begin
                    pixel_d = palette_rgb(frame_count_s[7:5]);
                end
                default: begin
                    pixel_d = PIX_BLACK;
                end
            endcase
        end
    end

    // Mode handshake: latest request wins; switch and ack only at the frame end.
    always_comb begin
        pend_flag_d   = pend_flag_q;
        pend_mode_d   = pend_mode_q;
        active_mode_d = active_mode_q;
        mode_ack_d    = 1'b0;
        if (frame_tick_s) begin
            if (mode_req) begin
                active_mode_d = mode_e'(mode_sel);
                mode_ack_d    = 1'b1;
                pend_flag_d   = 1'b0;
            end else if (pend_flag_q) begin
                active_mode_d = pend_mode_q;
                mode_ack_d    = 1'b1;
                pend_flag_d   = 1'b0;
            end else begin
                mode_ack_d    = 1'b0;
            end
        end else if (mode_req) begin
            pend_mode_d = mode_e'(mode_sel);
            pend_flag_d = 1'b1;
        end else begin
            mode_ack_d  = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            pixel_q       <= 12'h000;
            active_mode_q <= MODE_BARS;
            pend_mode_q   <= MODE_BARS;
            pend_flag_q   <= 1'b0;
            mode_ack_q    <= 1'b0;
            bar_idx_q     <= 3'd0;
            bar_pix_q     <= '0;
        end else begin
            pixel_q       <= pixel_d;
            active_mode_q <= active_mode_d;
            pend_mode_q   <= pend_mode_d;
            pend_flag_q   <= pend_flag_d;
            mode_ack_q    <= mode_ack_d;
            bar_idx_q     <= bar_idx_d;
            bar_pix_q     <= bar_pix_d;
        end
    end

    assign pixel_data  = pixel_q;
    assign active_mode = active_mode_q;
    assign mode_ack    = mode_ack_q;
    assign frame_count = frame_count_s;

endmodule
